// File: rtl/imm_pkg.sv
// imm_pkg: shared immediate-select codes, opcodes and the FIFO entry type
package imm_pkg;
  localparam int IMM_XLEN = 32;
  localparam logic [2:0] IMM_X = 3'd0;
  localparam logic [2:0] IMM_I = 3'd1;
  localparam logic [2:0] IMM_S = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;
  localparam logic [2:0] IMM_B = 3'd5;
  localparam logic [2:0] IMM_Z = 3'd6;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  typedef struct packed {
    logic [IMM_XLEN-1:0] pc;
    logic [IMM_XLEN-1:0] inst;
    logic [2:0]          sel;
    logic [IMM_XLEN-1:0] imm;
    logic                illegal;
  } imm_entry_t;
endpackage

// File: rtl/imm_sel_decode.sv
// imm_sel_decode: opcode/funct3 to immediate select and illegal flag; IMM_DECODE_ZIMM_EN enables the Z select
module imm_sel_decode
  import imm_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic       funct3_msb,
  output logic [2:0] sel,
  output logic       illegal
);
  logic [2:0] sys_sel;
  logic       sys_ill;
`ifdef IMM_DECODE_ZIMM_EN
  assign sys_sel = funct3_msb ? IMM_Z : IMM_I;
  assign sys_ill = 1'b0;
`else
  assign sys_sel = funct3_msb ? IMM_X : IMM_I;
  assign sys_ill = funct3_msb;
`endif
  // map the major opcode onto an immediate format
  always_comb begin
    sel = (opcode == OP_LUI || opcode == OP_AUIPC) ? IMM_U :
          opcode == OP_JAL    ? IMM_J :
          opcode == OP_BRANCH ? IMM_B :
          opcode == OP_STORE  ? IMM_S :
          (opcode == OP_LOAD || opcode == OP_OPIMM || opcode == OP_JALR) ? IMM_I :
          opcode == OP_SYSTEM ? sys_sel : IMM_X;
    illegal = opcode == OP_SYSTEM ? sys_ill :
              !(opcode inside {OP_LUI, OP_AUIPC, OP_JAL, OP_BRANCH, OP_STORE,
                               OP_LOAD, OP_OPIMM, OP_JALR, OP_OP});
  end
endmodule

// File: rtl/imm_decode_ctrl.sv
// imm_decode_ctrl: decode-stage immediate controller with a DEPTH-entry FIFO to execute; IMM_DECODE_ZIMM_EN enables Z immediates; XLEN must equal imm_pkg::IMM_XLEN
module imm_decode_ctrl
  import imm_pkg::*;
#(
  parameter int XLEN  = IMM_XLEN,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [XLEN-1:0]  io_in_inst,
  input  logic [XLEN-1:0]  io_in_pc,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [XLEN-1:0]  io_out_inst,
  output logic [XLEN-1:0]  io_out_pc,
  output logic [2:0]       io_out_sel,
  output logic [XLEN-1:0]  io_out_imm,
  output logic             io_out_illegal,
  input  logic             io_flush,
  output logic [CNT_W-1:0] io_illegal_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [31:0]      inst;
  logic [31:0]      i_imm;
  logic [31:0]      imm32;
  logic [2:0]       sel;
  logic             illegal;
  logic             enq;
  logic             deq;
  imm_entry_t       entry;
  imm_entry_t       head;
  imm_entry_t       mem_q [DEPTH];
  imm_entry_t       mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign inst = io_in_inst[31:0];
  imm_sel_decode u_sel (
    .opcode     (inst[6:0]),
    .funct3_msb (inst[14]),
    .sel        (sel),
    .illegal    (illegal)
  );
  // assemble the immediate for the decoded select; disabled SYSTEM encodings carry a zero immediate
  always_comb begin
    i_imm = {{20{inst[31]}}, inst[31:20]};
    imm32 = sel == IMM_I ? i_imm :
            sel == IMM_S ? {{20{inst[31]}}, inst[31:25], inst[11:7]} :
            sel == IMM_B ? {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0} :
            sel == IMM_U ? {inst[31:12], 12'b0} :
            sel == IMM_J ? {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0} :
            sel == IMM_Z ? {27'b0, inst[19:15]} :
            (sel == IMM_X && !(illegal && inst[6:0] == OP_SYSTEM)) ? (i_imm & ~32'd1) : '0;
    entry = '{pc: io_in_pc, inst: io_in_inst, sel: sel, imm: XLEN'($signed(imm32)), illegal: illegal};
  end
  // FIFO bookkeeping; flush wins over both enqueue and dequeue
  always_comb begin
    io_in_ready = count_q != CW'(DEPTH);
    io_out_valid = count_q != '0;
    enq = io_in_valid && io_in_ready && !io_flush;
    deq = io_out_valid && io_out_ready && !io_flush;
    mem_d = mem_q;
    if (enq) mem_d[wr_ptr_q] = entry;
    wr_ptr_d = io_flush ? '0 : wr_ptr_q + PW'(enq);
    rd_ptr_d = io_flush ? '0 : rd_ptr_q + PW'(deq);
    count_d = io_flush ? '0 : count_q + CW'(enq) - CW'(deq);
    cnt_d = (enq && illegal && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  // state registers with asynchronous active-low clear
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      cnt_q <= cnt_d;
    end
  end
  assign head = mem_q[rd_ptr_q];
  assign io_out_inst = head.inst;
  assign io_out_pc = head.pc;
  assign io_out_sel = head.sel;
  assign io_out_imm = head.imm;
  assign io_out_illegal = head.illegal;
  assign io_illegal_cnt = cnt_q;
endmodule

// File: tb/tb_imm_decode_ctrl.sv
// tb_imm_decode_ctrl: directed vectors for imm_decode_ctrl, Z-select expectations follow IMM_DECODE_ZIMM_EN
module tb_imm_decode_ctrl;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_in_valid = 1'b0, io_in_ready;
  logic [31:0] io_in_inst = '0, io_in_pc = '0;
  logic        io_out_valid, io_out_ready = 1'b1;
  logic [31:0] io_out_inst, io_out_pc, io_out_imm;
  logic [2:0]  io_out_sel;
  logic        io_out_illegal;
  logic        io_flush = 1'b0;
  logic [15:0] io_illegal_cnt;
  logic        v2 = 1'b0, rdy2, ov2;
  logic [31:0] inst2 = 32'h0000007F, oi2, op2, om2;
  logic [2:0]  os2;
  logic        ol2;
  logic [1:0]  cnt2;
  int n_chk = 0;
  int n_err = 0;
  int exp_cnt = 0;
  logic [31:0] pc = 32'h1000;
  always #5 clock = ~clock;
  imm_decode_ctrl #(.XLEN(32), .DEPTH(2), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .io_in_inst(io_in_inst), .io_in_pc(io_in_pc), .io_out_valid(io_out_valid),
    .io_out_ready(io_out_ready), .io_out_inst(io_out_inst), .io_out_pc(io_out_pc),
    .io_out_sel(io_out_sel), .io_out_imm(io_out_imm), .io_out_illegal(io_out_illegal),
    .io_flush(io_flush), .io_illegal_cnt(io_illegal_cnt)
  );
  imm_decode_ctrl #(.XLEN(32), .DEPTH(2), .CNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .io_in_valid(v2), .io_in_ready(rdy2),
    .io_in_inst(inst2), .io_in_pc(32'h0), .io_out_valid(ov2),
    .io_out_ready(1'b1), .io_out_inst(oi2), .io_out_pc(op2),
    .io_out_sel(os2), .io_out_imm(om2), .io_out_illegal(ol2),
    .io_flush(1'b0), .io_illegal_cnt(cnt2)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    @(negedge clock);
  endtask
  task automatic offer(input logic [31:0] inst, input logic [31:0] a);
    io_in_valid = 1'b1;
    io_in_inst = inst;
    io_in_pc = a;
    tick();
    io_in_valid = 1'b0;
  endtask
  task automatic decode(input string tag, input logic [31:0] inst, input logic [2:0] sel,
                        input logic [31:0] imm, input logic ill);
    io_out_ready = 1'b1;
    pc += 4;
    offer(inst, pc);
    if (ill) exp_cnt++;
    check({tag, ".valid"}, 32'(io_out_valid), 32'd1);
    check({tag, ".inst"}, io_out_inst, inst);
    check({tag, ".pc"}, io_out_pc, pc);
    check({tag, ".sel"}, 32'(io_out_sel), 32'(sel));
    check({tag, ".imm"}, io_out_imm, imm);
    check({tag, ".illegal"}, 32'(io_out_illegal), 32'(ill));
    check({tag, ".cnt"}, 32'(io_illegal_cnt), exp_cnt);
    tick();
    check({tag, ".drained"}, 32'(io_out_valid), 32'd0);
  endtask
  initial begin
    repeat (2) @(negedge clock);
    reset = 1'b1;
    check("rst.in_ready", 32'(io_in_ready), 32'd1);
    check("rst.out_valid", 32'(io_out_valid), 32'd0);
    check("rst.cnt", 32'(io_illegal_cnt), 32'd0);
    check("rst.out_inst", io_out_inst, 32'd0);
    check("rst.out_imm", io_out_imm, 32'd0);
    tick();
    decode("addi", 32'h00500093, 3'd1, 32'h00000005, 1'b0);
    decode("beq", 32'hFE000EE3, 3'd5, 32'hFFFFFFFC, 1'b0);
    decode("lui", 32'h123450B7, 3'd3, 32'h12345000, 1'b0);
    decode("sw", 32'hFE112C23, 3'd2, 32'hFFFFFFF8, 1'b0);
    decode("jal", 32'h008000EF, 3'd4, 32'h00000008, 1'b0);
    decode("add", 32'h003100B3, 3'd0, 32'h00000002, 1'b0);
    decode("ill", 32'h0000007F, 3'd0, 32'h00000000, 1'b1);
    decode("csrrw", 32'h00029073, 3'd1, 32'h00000000, 1'b0);
`ifdef IMM_DECODE_ZIMM_EN
    decode("zimm", 32'h0002E073, 3'd6, 32'h00000005, 1'b0);
`else
    decode("zimm", 32'h0002E073, 3'd0, 32'h00000000, 1'b1);
`endif
    io_out_ready = 1'b0;
    offer(32'h00100093, 32'h200);
    check("bp.ready1", 32'(io_in_ready), 32'd1);
    offer(32'h00200093, 32'h204);
    check("bp.ready2", 32'(io_in_ready), 32'd0);
    offer(32'h00300093, 32'h208);
    check("bp.head_pc", io_out_pc, 32'h200);
    check("bp.head_imm", io_out_imm, 32'd1);
    check("bp.still_full", 32'(io_in_ready), 32'd0);
    io_in_valid = 1'b1;
    io_out_ready = 1'b1;
    tick();
    check("bp.drain1_pc", io_out_pc, 32'h204);
    check("bp.ready_back", 32'(io_in_ready), 32'd1);
    tick();
    io_in_valid = 1'b0;
    check("bp.drain2_pc", io_out_pc, 32'h208);
    check("bp.drain2_imm", io_out_imm, 32'd3);
    tick();
    check("bp.empty", 32'(io_out_valid), 32'd0);
    io_out_ready = 1'b0;
    offer(32'h00100093, 32'h300);
    offer(32'h00200093, 32'h304);
    io_flush = 1'b1;
    io_in_valid = 1'b1;
    io_in_inst = 32'h0000007F;
    tick();
    io_flush = 1'b0;
    io_in_valid = 1'b0;
    check("flush2.valid", 32'(io_out_valid), 32'd0);
    check("flush2.ready", 32'(io_in_ready), 32'd1);
    offer(32'h00100093, 32'h400);
    io_flush = 1'b1;
    io_in_valid = 1'b1;
    io_in_inst = 32'h0000007F;
    io_in_pc = 32'h404;
    tick();
    io_flush = 1'b0;
    io_in_valid = 1'b0;
    check("flush1.valid", 32'(io_out_valid), 32'd0);
    check("flush1.cnt", 32'(io_illegal_cnt), exp_cnt);
    decode("postflush", 32'h123450B7, 3'd3, 32'h12345000, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      v2 = 1'b1;
      tick();
      v2 = 1'b0;
      check($sformatf("sat.cnt%0d", k), 32'(cnt2), (k > 3) ? 32'd3 : 32'(k));
    end
    io_out_ready = 1'b0;
    offer(32'h0000007F, 32'h500);
    offer(32'h00100093, 32'h504);
    check("mid.cnt_pre", 32'(io_illegal_cnt), exp_cnt + 1);
    #2 reset = 1'b0;
    #1;
    check("mid.valid", 32'(io_out_valid), 32'd0);
    check("mid.ready", 32'(io_in_ready), 32'd1);
    check("mid.cnt", 32'(io_illegal_cnt), 32'd0);
    check("mid.cnt2", 32'(cnt2), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    exp_cnt = 0;
    decode("after_rst", 32'h00500093, 3'd1, 32'h00000005, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
